peg_l2_mac_pause_gen: RTL and testbench

TX-side PAUSE frame generator for the L2 MAC; it is the transmit counterpart of the receive-path pause counter.
- Watches a local congestion request and emits IEEE 802.3x MAC-control PAUSE frames (XOFF with configured quanta, XON with quanta 0) as a 64-bit beat stream.
- The stream feeds the MAC TX arbiter, which inserts it ahead of data frames and appends the FCS.
- While congestion persists, XOFF is refreshed periodically.

---
 rtl/peg_l2_mac_pkg.sv | 53 +++++
 rtl/peg_l2_mac_pause_refresh_tmr.sv | 32 +++
 rtl/peg_l2_mac_pause_gen.sv | 120 ++++++++++++
 tb/tb_peg_l2_mac_pause_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peg_l2_mac_pkg.sv
// Shared L2 MAC definitions: MAC-control PAUSE frame constants, beat payload
// type and the pause FSM state encoding used by the TX generator.
package peg_l2_mac_pkg;

    localparam int unsigned DATA_W            = 64;
    localparam int unsigned BCNT_W            = 3;
    localparam int unsigned MAC_ADDR_W        = 48;
    localparam int unsigned QUANTA_W          = 16;
    localparam int unsigned QUANTA_SHIFT      = 3;
    localparam int unsigned REFRESH_W         = QUANTA_W + QUANTA_SHIFT;
    localparam int unsigned PAUSE_FRAME_BEATS = 8;
    localparam int unsigned BEAT_IDX_W        = 3;
    localparam int unsigned PAUSE_LAST_BCNT   = 4;

    localparam logic [MAC_ADDR_W-1:0] PAUSE_DA     = 48'h0180C2000001;
    localparam logic [15:0]           ETH_TYPE     = 16'h8808;
    localparam logic [15:0]           PAUSE_OPCODE = 16'h0001;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(PAUSE_FRAME_BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } pause_state_e;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BCNT_W-1:0] bcnt;
        logic [DATA_W-1:0] data;
    } pause_beat_t;

    // Build one beat of a PAUSE frame; first wire byte lands on [63:56].
    function automatic pause_beat_t pause_make_beat(
        input logic [BEAT_IDX_W-1:0] idx,
        input logic [MAC_ADDR_W-1:0] sa,
        input logic [QUANTA_W-1:0]   ptime
    );
        pause_beat_t b;
        b      = '0;
        b.sop  = (idx == '0);
        b.eop  = (idx == LAST_BEAT);
        b.bcnt = b.eop ? BCNT_W'(PAUSE_LAST_BCNT) : '0;
        case (idx)
            BEAT_IDX_W'(0): b.data = {PAUSE_DA, sa[47:32]};
            BEAT_IDX_W'(1): b.data = {sa[31:0], ETH_TYPE, PAUSE_OPCODE};
            BEAT_IDX_W'(2): b.data = {ptime, {(DATA_W - QUANTA_W){1'b0}}};
            default:        b.data = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/peg_l2_mac_pause_refresh_tmr.sv
// XOFF refresh timer: counts down the re-send period (in clocks) while XOFF
// is advertised and flags when a refresh frame is due.
module peg_l2_mac_pause_refresh_tmr
    import peg_l2_mac_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [QUANTA_W-1:0] refresh_interval,
    input  logic                xoff_active,
    input  logic                load,
    input  logic                clear,
    output logic                refresh_expired_c
);

    logic [REFRESH_W-1:0] cnt_q;

    // Saturates at zero, so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= {refresh_interval, {QUANTA_SHIFT{1'b0}}};
        end else if (xoff_active && (cnt_q != '0)) begin
            cnt_q <= cnt_q - REFRESH_W'(1);
        end
    end

    assign refresh_expired_c = xoff_active && (refresh_interval != '0) && (cnt_q == '0);

endmodule

// File: rtl/peg_l2_mac_pause_gen.sv
// TX PAUSE frame generator: turns the RX congestion level into XOFF/XON
// MAC-control frames streamed as 64-bit beats toward the TX arbiter.
module peg_l2_mac_pause_gen
    import peg_l2_mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause_gen_en,
    input  logic [MAC_ADDR_W-1:0] mac_addr,
    input  logic [QUANTA_W-1:0]   xoff_quanta,
    input  logic [QUANTA_W-1:0]   refresh_interval,
    input  logic                  xoff_req,
    output logic                  tx_pause_valid,
    output logic                  tx_pause_sop,
    output logic                  tx_pause_eop,
    output logic [BCNT_W-1:0]     tx_pause_bcnt,
    output logic [DATA_W-1:0]     tx_pause_data,
    input  logic                  tx_pause_ready,
    output logic                  xoff_active,
    output logic                  pause_tx_busy
);

    pause_state_e              state_q, state_d;
    logic [BEAT_IDX_W-1:0]     beat_q, beat_d;
    logic [QUANTA_W-1:0]       frame_time_q, frame_time_d;
    logic [MAC_ADDR_W-1:0]     frame_sa_q, frame_sa_d;
    pause_beat_t               beat_out_q, beat_out_d;
    logic                      valid_q, valid_d;
    logic                      xoff_active_q, xoff_active_d;
    logic                      eff_req;
    logic                      refresh_expired;
    logic                      tmr_load, tmr_clear;
    logic [QUANTA_W-1:0]       new_time;

    assign eff_req  = xoff_req && pause_gen_en && (xoff_quanta != '0);
    assign new_time = eff_req ? xoff_quanta : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            frame_time_q  <= '0;
            frame_sa_q    <= '0;
            beat_out_q    <= '0;
            valid_q       <= 1'b0;
            xoff_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            frame_time_q  <= frame_time_d;
            frame_sa_q    <= frame_sa_d;
            beat_out_q    <= beat_out_d;
            valid_q       <= valid_d;
            xoff_active_q <= xoff_active_d;
        end
    end

    // Next-state and next-beat selection; beat registers only move on accept.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        frame_time_d  = frame_time_q;
        frame_sa_d    = frame_sa_q;
        beat_out_d    = beat_out_q;
        valid_d       = valid_q;
        xoff_active_d = xoff_active_q;
        tmr_load      = 1'b0;
        tmr_clear     = 1'b0;
        case (state_q)
            IDLE: begin
                if ((eff_req != xoff_active_q) ||
                    (xoff_active_q && eff_req && refresh_expired)) begin
                    state_d      = SEND;
                    beat_d       = '0;
                    frame_time_d = new_time;
                    frame_sa_d   = mac_addr;
                    valid_d      = 1'b1;
                    beat_out_d   = pause_make_beat('0, mac_addr, new_time);
                end
            end
            SEND: begin
                if (valid_q && tx_pause_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d       = IDLE;
                        beat_d        = '0;
                        valid_d       = 1'b0;
                        beat_out_d    = '0;
                        xoff_active_d = (frame_time_q != '0);
                        tmr_load      = (frame_time_q != '0);
                        tmr_clear     = (frame_time_q == '0);
                    end else begin
                        beat_d     = beat_q + BEAT_IDX_W'(1);
                        beat_out_d = pause_make_beat(beat_q + BEAT_IDX_W'(1),
                                                     frame_sa_q, frame_time_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    peg_l2_mac_pause_refresh_tmr u_refresh_tmr (
        .clk               (clk),
        .rst_n             (rst_n),
        .refresh_interval  (refresh_interval),
        .xoff_active       (xoff_active_q),
        .load              (tmr_load),
        .clear             (tmr_clear),
        .refresh_expired_c (refresh_expired)
    );

    assign tx_pause_valid = valid_q;
    assign tx_pause_sop   = beat_out_q.sop;
    assign tx_pause_eop   = beat_out_q.eop;
    assign tx_pause_bcnt  = beat_out_q.bcnt;
    assign tx_pause_data  = beat_out_q.data;
    assign xoff_active    = xoff_active_q;
    assign pause_tx_busy  = (state_q == SEND);

endmodule

// File: tb/tb_peg_l2_mac_pause_gen.sv
// Bench for peg_l2_mac_pause_gen: directed scenarios plus random traffic,
// checked every cycle against a frame-level byte model.
module tb_peg_l2_mac_pause_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pause_gen_en = 1'b0;
    logic [47:0] mac_addr = '0;
    logic [15:0] xoff_quanta = '0;
    logic [15:0] refresh_interval = '0;
    logic        xoff_req = 1'b0;
    logic        tx_pause_valid, tx_pause_sop, tx_pause_eop;
    logic [2:0]  tx_pause_bcnt;
    logic [63:0] tx_pause_data;
    logic        tx_pause_ready = 1'b1;
    logic        xoff_active, pause_tx_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    peg_l2_mac_pause_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pause_gen_en     (pause_gen_en),
        .mac_addr         (mac_addr),
        .xoff_quanta      (xoff_quanta),
        .refresh_interval (refresh_interval),
        .xoff_req         (xoff_req),
        .tx_pause_valid   (tx_pause_valid),
        .tx_pause_sop     (tx_pause_sop),
        .tx_pause_eop     (tx_pause_eop),
        .tx_pause_bcnt    (tx_pause_bcnt),
        .tx_pause_data    (tx_pause_data),
        .tx_pause_ready   (tx_pause_ready),
        .xoff_active      (xoff_active),
        .pause_tx_busy    (pause_tx_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: a frame is a 64-byte image (60 bytes + pad) walked 8 bytes per accept.
    byte unsigned m_frame[64];
    bit          m_busy = 0;
    int          m_idx = 0;
    bit          m_xa = 0;
    int          m_refresh = 0;
    int          m_time = 0;
    bit          m_old_xa, m_reloaded, m_eff, m_expired;

    function automatic void build_frame(input logic [47:0] sa, input logic [15:0] t);
        logic [47:0] da;
        da = 48'h0180C2000001;
        for (int i = 0; i < 64; i++) m_frame[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            m_frame[i]     = da[47 - 8*i -: 8];
            m_frame[6 + i] = sa[47 - 8*i -: 8];
        end
        m_frame[12] = 8'h88; m_frame[13] = 8'h08;
        m_frame[14] = 8'h00; m_frame[15] = 8'h01;
        m_frame[16] = t[15:8]; m_frame[17] = t[7:0];
    endfunction

    function automatic logic [63:0] beat_word(input int idx);
        logic [63:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d = {d[55:0], m_frame[idx*8 + k]};
        return d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_idx = 0; m_xa = 0; m_refresh = 0; m_time = 0;
        end else begin
            m_old_xa   = m_xa;
            m_reloaded = 0;
            m_eff      = xoff_req && pause_gen_en && (xoff_quanta != 0);
            if (!m_busy) begin
                m_expired = m_xa && (refresh_interval != 0) && (m_refresh == 0);
                if ((m_eff != m_xa) || (m_xa && m_eff && m_expired)) begin
                    m_busy = 1;
                    m_idx  = 0;
                    m_time = m_eff ? int'(xoff_quanta) : 0;
                    build_frame(mac_addr, 16'(m_time));
                end
            end else if (tx_pause_ready) begin
                if (m_idx == 7) begin
                    m_busy     = 0;
                    m_xa       = (m_time != 0);
                    m_refresh  = m_xa ? int'(refresh_interval) * 8 : 0;
                    m_reloaded = 1;
                end else begin
                    m_idx++;
                end
            end
            if (!m_reloaded && m_old_xa && m_refresh > 0) m_refresh--;
        end
    end

    // Capture of accepted beats for the directed checks.
    logic [63:0] acc_q[$];
    int sop_count = 0, eop_count = 0, sop_cyc = 0, eop_cyc = 0;
    logic [2:0] last_eop_bcnt = '0;

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        chk("valid", 64'(tx_pause_valid), 64'(m_busy));
        chk("sop",   64'(tx_pause_sop),   64'(m_busy && m_idx == 0));
        chk("eop",   64'(tx_pause_eop),   64'(m_busy && m_idx == 7));
        chk("bcnt",  64'(tx_pause_bcnt),  (m_busy && m_idx == 7) ? 64'd4 : 64'd0);
        chk("data",  tx_pause_data,       m_busy ? beat_word(m_idx) : 64'd0);
        chk("xoff_active", 64'(xoff_active), 64'(m_xa));
        chk("busy",  64'(pause_tx_busy),  64'(m_busy));
        if (rst_n && tx_pause_valid && tx_pause_ready) begin
            acc_q.push_back(tx_pause_data);
            if (tx_pause_sop) begin sop_count++; sop_cyc = cyc; end
            if (tx_pause_eop) begin eop_count++; eop_cyc = cyc; last_eop_bcnt = tx_pause_bcnt; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_eop(input string name, input int budget, input bit rnd);
        int start, n;
        start = eop_count;
        n = 0;
        while (eop_count == start && n < budget) begin
            if (rnd) tx_pause_ready = ($urandom_range(0, 99) < 60);
            tick();
            n++;
        end
        tx_pause_ready = 1'b1;
        if (eop_count == start) begin
            tests++; fails++;
            $display("FAIL %s: no eop within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_sop(input string name, input int budget);
        int start, n;
        start = sop_count;
        n = 0;
        while (sop_count == start && n < budget) begin
            tick();
            n++;
        end
        if (sop_count == start) begin
            tests++; fails++;
            $display("FAIL %s: no sop within %0d cycles", name, budget);
        end
    endtask

    localparam logic [63:0] B0 = 64'h0180_C200_0001_0200;
    localparam logic [63:0] B1 = 64'h1122_3344_8808_0001;

    int sc, ec;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 64'(tx_pause_valid), 64'd0);
        chk("reset_xoff_active", 64'(xoff_active), 64'd0);
        rst_n = 1'b1;
        tick();

        // First XOFF frame
        mac_addr = 48'h0200_1122_3344;
        xoff_quanta = 16'h00FF;
        refresh_interval = 16'd0;
        pause_gen_en = 1'b1;
        acc_q.delete();
        xoff_req = 1'b1;
        wait_eop("xoff1", 40, 1'b0);
        chk("xoff1_beats", 64'(acc_q.size()), 64'd8);
        if (acc_q.size() == 8) begin
            chk("xoff1_b0", acc_q[0], B0);
            chk("xoff1_b1", acc_q[1], B1);
            chk("xoff1_b2", acc_q[2], 64'h00FF_0000_0000_0000);
            chk("xoff1_b7", acc_q[7], 64'd0);
        end
        chk("xoff1_bcnt", 64'(last_eop_bcnt), 64'd4);
        chk("xoff1_active_after", 64'(xoff_active), 64'd1);

        // XON on request release
        acc_q.delete();
        xoff_req = 1'b0;
        wait_eop("xon1", 40, 1'b0);
        if (acc_q.size() == 8) chk("xon1_b2", acc_q[2], 64'd0);
        chk("xon1_active_after", 64'(xoff_active), 64'd0);

        // Refresh spacing with interval 4 quanta
        refresh_interval = 16'd4;
        xoff_req = 1'b1;
        wait_eop("refresh_first", 40, 1'b0);
        ec = eop_cyc;
        wait_sop("refresh_sop", 60);
        chk("refresh_spacing", 64'(sop_cyc - ec), 64'd34);
        refresh_interval = 16'd0;
        wait_eop("refresh_frame", 40, 1'b0);
        sc = sop_count;
        repeat (100) tick();
        chk("no_refresh_when_zero", 64'(sop_count), 64'(sc));
        chk("still_xoff", 64'(xoff_active), 64'd1);

        // XON under random backpressure
        acc_q.delete();
        xoff_req = 1'b0;
        wait_eop("stall_xon", 400, 1'b1);
        chk("stall_beats", 64'(acc_q.size()), 64'd8);
        if (acc_q.size() == 8) chk("stall_b1", acc_q[1], B1);

        // Short request pulse during an XON frame
        xoff_req = 1'b1;
        wait_eop("pulse_xoff", 40, 1'b0);
        acc_q.delete();
        xoff_req = 1'b0;
        tick(); tick();
        xoff_req = 1'b1;
        repeat (3) tick();
        xoff_req = 1'b0;
        wait_eop("pulse_xon", 40, 1'b0);
        if (acc_q.size() >= 3) chk("pulse_xon_b2", acc_q[2], 64'd0);
        sc = sop_count;
        repeat (20) tick();
        chk("pulse_no_frame", 64'(sop_count), 64'(sc));

        // Request still high after XON completes -> XOFF follows
        xoff_req = 1'b1;
        wait_eop("held_xoff", 40, 1'b0);
        xoff_req = 1'b0;
        wait_sop("held_xon_sop", 20);
        xoff_req = 1'b1;
        wait_eop("held_xon", 40, 1'b0);
        wait_eop("held_xoff2", 40, 1'b0);
        chk("held_xoff_active", 64'(xoff_active), 64'd1);

        // Disable while XOFF advertised
        acc_q.delete();
        pause_gen_en = 1'b0;
        wait_eop("disable_xon", 40, 1'b0);
        if (acc_q.size() == 8) chk("disable_b2", acc_q[2], 64'd0);
        chk("disable_active", 64'(xoff_active), 64'd0);
        xoff_req = 1'b0;
        pause_gen_en = 1'b1;
        repeat (5) tick();

        // Reset in the middle of a frame
        xoff_req = 1'b1;
        wait_sop("rst_sop", 20);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(tx_pause_valid), 64'd0);
        chk("rst_xoff_active", 64'(xoff_active), 64'd0);
        tick();
        acc_q.delete();
        rst_n = 1'b1;
        wait_eop("post_rst", 40, 1'b0);
        chk("post_rst_beats", 64'(acc_q.size()), 64'd8);
        if (acc_q.size() == 8) begin
            chk("post_rst_b0", acc_q[0], B0);
            chk("post_rst_b2", acc_q[2], 64'h00FF_0000_0000_0000);
        end

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            tx_pause_ready = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 99) < 3) xoff_req = ~xoff_req;
            if (pause_gen_en ? ($urandom_range(0, 999) < 5) : ($urandom_range(0, 99) < 5))
                pause_gen_en = ~pause_gen_en;
            if ($urandom_range(0, 99) < 1)
                xoff_quanta = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 99) < 1) refresh_interval = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 999) < 5) mac_addr = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 999) < 2) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        tx_pause_ready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
